// File: rtl/wb_txn_pkg.sv
// Shared types and constants for the single-transaction Wishbone master.
// Holds FSM state codes, response status encodings and default widths.
package wb_txn_pkg;

    localparam int DEF_ADR_W   = 30;
    localparam int DEF_DAT_W   = 32;
    localparam int DEF_TIMEOUT = 1024;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUS  = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    typedef logic [1:0] status_t;
    localparam status_t STATUS_OK      = 2'd0;
    localparam status_t STATUS_ERR     = 2'd1;
    localparam status_t STATUS_TIMEOUT = 2'd2;

    // err dominates ack; either one dominates a simultaneous timeout
    function automatic status_t term_status(input logic ack, input logic err);
        if (err) begin
            return STATUS_ERR;
        end else if (ack) begin
            return STATUS_OK;
        end else begin
            return STATUS_TIMEOUT;
        end
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts cycles while enabled, flags the last allowed one.
module wb_timeout_ctr
    import wb_txn_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;

    // Next count: clear wins over counting
    always_comb begin
        if (clear) begin
            cnt_d = 16'd0;
        end else if (enable) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/wb_txn_master.sv
// Command/response to classic Wishbone single-cycle master with timeout.
// One transaction in flight; all outputs come straight from registers.
module wb_txn_master
    import wb_txn_pkg::*;
#(
    parameter int ADR_W   = DEF_ADR_W,
    parameter int DAT_W   = DEF_DAT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADR_W-1:0]   cmd_adr,
    input  logic [DAT_W-1:0]   cmd_dat,
    input  logic [DAT_W/8-1:0] cmd_sel,
    input  logic               cmd_we,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DAT_W-1:0]   rsp_dat,
    output logic [1:0]         rsp_status,
    output logic [ADR_W-1:0]   wishbone_adr,
    output logic [DAT_W-1:0]   wishbone_dat_w,
    output logic [DAT_W/8-1:0] wishbone_sel,
    output logic               wishbone_we,
    output logic               wishbone_cyc,
    output logic               wishbone_stb,
    output logic [2:0]         wishbone_cti,
    output logic [1:0]         wishbone_bte,
    input  logic [DAT_W-1:0]   wishbone_dat_r,
    input  logic               wishbone_ack,
    input  logic               wishbone_err,
    output logic [15:0]        txn_count
);

    localparam int SEL_W = DAT_W / 8;

    state_t             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               cyc_q, cyc_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [DAT_W-1:0]   dat_w_q, dat_w_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               we_q, we_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    status_t            rsp_status_q, rsp_status_d;
    logic [15:0]        txn_count_q, txn_count_d;

    logic    expired_s, accept_s, term_s, hs_s, in_bus_s;
    status_t status_s;

    assign in_bus_s = (state_q == ST_BUS);
    assign accept_s = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
    assign term_s   = in_bus_s && (wishbone_ack || wishbone_err || expired_s);
    assign hs_s     = (state_q == ST_RESP) && rsp_valid_q && rsp_ready;
    assign status_s = term_status(wishbone_ack, wishbone_err);

    wb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept_s),
        .enable  (in_bus_s),
        .expired (expired_s)
    );

    // Transaction FSM and datapath next-state
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        cyc_d        = cyc_q;
        adr_d        = adr_q;
        dat_w_d      = dat_w_q;
        sel_d        = sel_q;
        we_d         = we_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        txn_count_d  = txn_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d     = ST_BUS;
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    adr_d       = cmd_adr;
                    dat_w_d     = cmd_dat;
                    sel_d       = cmd_sel;
                    we_d        = cmd_we;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_BUS: begin
                if (term_s) begin
                    state_d      = ST_RESP;
                    cyc_d        = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = status_s;
                    rsp_dat_d    = (status_s == STATUS_OK) ? wishbone_dat_r : {DAT_W{1'b0}};
                end else begin
                    cyc_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (hs_s) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    txn_count_d = txn_count_q + 16'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b0;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cmd_ready_q  <= 1'b0;
            cyc_q        <= 1'b0;
            adr_q        <= {ADR_W{1'b0}};
            dat_w_q      <= {DAT_W{1'b0}};
            sel_q        <= {SEL_W{1'b0}};
            we_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_dat_q    <= {DAT_W{1'b0}};
            rsp_status_q <= STATUS_OK;
            txn_count_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            cyc_q        <= cyc_d;
            adr_q        <= adr_d;
            dat_w_q      <= dat_w_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            txn_count_q  <= txn_count_d;
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign wishbone_cyc   = cyc_q;
    assign wishbone_stb   = cyc_q;
    assign wishbone_adr   = adr_q;
    assign wishbone_dat_w = dat_w_q;
    assign wishbone_sel   = sel_q;
    assign wishbone_we    = we_q;
    assign wishbone_cti   = 3'b000;
    assign wishbone_bte   = 2'b00;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_dat        = rsp_dat_q;
    assign rsp_status     = rsp_status_q;
    assign txn_count      = txn_count_q;

endmodule

// File: tb/tb_wb_txn_master.sv
// Self-checking bench for wb_txn_master: scripted slave, response scoreboard.
module tb_wb_txn_master;

    localparam int TMO    = 8;
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  status;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [29:0] cmd_adr = 30'd0;
    logic [31:0] cmd_dat = 32'd0;
    logic [3:0]  cmd_sel = 4'd0;
    logic        cmd_we = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic [29:0] wishbone_adr;
    logic [31:0] wishbone_dat_w;
    logic [3:0]  wishbone_sel;
    logic        wishbone_we;
    logic        wishbone_cyc;
    logic        wishbone_stb;
    logic [2:0]  wishbone_cti;
    logic [1:0]  wishbone_bte;
    logic [31:0] wishbone_dat_r = 32'd0;
    logic        wishbone_ack = 1'b0;
    logic        wishbone_err = 1'b0;
    logic [15:0] txn_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_count = 16'd0;
    rsp_t        exp_q[$];

    wb_txn_master #(.ADR_W(30), .DAT_W(32), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_adr        (cmd_adr),
        .cmd_dat        (cmd_dat),
        .cmd_sel        (cmd_sel),
        .cmd_we         (cmd_we),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_dat        (rsp_dat),
        .rsp_status     (rsp_status),
        .wishbone_adr   (wishbone_adr),
        .wishbone_dat_w (wishbone_dat_w),
        .wishbone_sel   (wishbone_sel),
        .wishbone_we    (wishbone_we),
        .wishbone_cyc   (wishbone_cyc),
        .wishbone_stb   (wishbone_stb),
        .wishbone_cti   (wishbone_cti),
        .wishbone_bte   (wishbone_bte),
        .wishbone_dat_r (wishbone_dat_r),
        .wishbone_ack   (wishbone_ack),
        .wishbone_err   (wishbone_err),
        .txn_count      (txn_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One command through the DUT; slave answers per kind on bus cycle 'delay'
    task automatic run_txn(input logic [29:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                           input logic we, input int delay, input int kind,
                           input logic [31:0] rdata, input int hold);
        rsp_t e;
        rsp_t got;
        int   n;
        check_eq("cmd_ready_idle", {127'd0, cmd_ready}, 128'd1);
        e.dat    = (kind == K_ACK) ? rdata : 32'd0;
        e.status = (kind == K_ACK) ? 2'd0 : ((kind == K_NONE) ? 2'd2 : 2'd1);
        exp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cmd_we    = we;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_adr   = ~adr;
        cmd_dat   = ~dat;
        cmd_sel   = ~sel;
        cmd_we    = ~we;
        n = 0;
        while (wishbone_cyc && n < 40) begin
            check_eq("bus_hold",
                     {wishbone_cyc, wishbone_stb, wishbone_we, wishbone_sel, wishbone_adr,
                      wishbone_dat_w, wishbone_cti, wishbone_bte, cmd_ready},
                     {1'b1, 1'b1, we, sel, adr, dat, 3'b000, 2'b00, 1'b0});
            if (n == delay && kind != K_NONE) begin
                wishbone_ack   = (kind == K_ACK) || (kind == K_BOTH);
                wishbone_err   = (kind == K_ERR) || (kind == K_BOTH);
                wishbone_dat_r = rdata;
            end else begin
                wishbone_ack   = 1'b0;
                wishbone_err   = 1'b0;
                wishbone_dat_r = 32'hBAD0_0000 ^ 32'(n);
            end
            @(negedge clk);
            n++;
        end
        wishbone_ack   = 1'b0;
        wishbone_err   = 1'b0;
        wishbone_dat_r = 32'h5555_AAAA;
        check_eq("cyc_cycles", 128'(n), (kind == K_NONE) ? 128'(TMO) : 128'(delay + 1));
        for (int i = 0; i < hold; i++) begin
            check_eq("rsp_hold", {rsp_valid, cmd_ready, wishbone_cyc, rsp_status, rsp_dat},
                     {1'b1, 1'b0, 1'b0, e.status, e.dat});
            wishbone_ack = i[0];
            wishbone_err = ~i[0];
            @(negedge clk);
        end
        wishbone_ack = 1'b0;
        wishbone_err = 1'b0;
        check_eq("rsp_valid", {127'd0, rsp_valid}, 128'd1);
        rsp_ready = 1'b1;
        got = exp_q.pop_front();
        check_eq("rsp_dat", 128'(rsp_dat), 128'(got.dat));
        check_eq("rsp_status", 128'(rsp_status), 128'(got.status));
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        check_eq("after_hs", {126'd0, rsp_valid, cmd_ready}, 128'd1);
        check_eq("txn_count", 128'(txn_count), 128'(exp_count));
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_ctl", {wishbone_cyc, wishbone_stb, wishbone_we, rsp_valid, cmd_ready}, 128'd0);
        check_eq("rst_bus", {wishbone_adr, wishbone_dat_w, wishbone_sel}, 128'd0);
        check_eq("rst_rsp", {rsp_dat, rsp_status, txn_count, wishbone_cti, wishbone_bte}, 128'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("ready_after_rst", {127'd0, cmd_ready}, 128'd1);

        // Stray ack/err/rsp_ready while idle must change nothing
        wishbone_ack = 1'b1;
        wishbone_err = 1'b1;
        rsp_ready    = 1'b1;
        @(negedge clk);
        wishbone_ack = 1'b0;
        wishbone_err = 1'b0;
        rsp_ready    = 1'b0;
        @(negedge clk);
        check_eq("idle_ignore", {rsp_valid, wishbone_cyc, cmd_ready, txn_count}, {1'b0, 1'b0, 1'b1, 16'd0});

        run_txn(30'h10, 32'h0,        4'h0, 1'b0, 1,       K_ACK,  32'hDEADBEEF, 0);
        run_txn(30'h04, 32'h12345678, 4'hF, 1'b1, 3,       K_ACK,  32'hCAFE0001, 0);
        run_txn(30'h08, 32'h0,        4'h3, 1'b0, 0,       K_ACK,  32'hA5A55A5A, 5);
        run_txn(30'h0C, 32'h0BADF00D, 4'h1, 1'b1, 0,       K_ACK,  32'h00000001, 0);
        run_txn(30'h20, 32'h0,        4'hF, 1'b0, 0,       K_NONE, 32'h0,        1);
        run_txn(30'h24, 32'h11112222, 4'hC, 1'b1, 0,       K_BOTH, 32'h77778888, 0);
        run_txn(30'h28, 32'h0,        4'hF, 1'b0, 2,       K_ERR,  32'h99990000, 2);
        run_txn(30'h2C, 32'h0,        4'hF, 1'b0, TMO - 1, K_ACK,  32'h13572468, 0);

        // Reset while a bus cycle is open
        cmd_valid = 1'b1;
        cmd_adr   = 30'h30;
        cmd_we    = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_bus_cyc", {127'd0, wishbone_cyc}, 128'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_ctl", {wishbone_cyc, wishbone_stb, rsp_valid, cmd_ready}, 128'd0);
        check_eq("mid_rst_cnt", 128'(txn_count), 128'd0);
        reset = 1'b0;
        exp_count = 16'd0;
        @(negedge clk);
        check_eq("ready_after_mid_rst", {127'd0, cmd_ready}, 128'd1);

        run_txn(30'h3FFF_FFFF, 32'hFFFF_FFFF, 4'hF, 1'b1, 1, K_ACK, 32'h0F0F0F0F, 0);
        check_eq("queue_empty", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_txn_master.md
WB_TXN_MASTER -- requirements
Module: wb_txn_master

Interface
REQ-001 Parameter ADR_W, 30, Wishbone word-address width.
REQ-002 Parameter DAT_W, 32, Wishbone data width; SEL width is DAT_W/8.
REQ-003 Parameter TIMEOUT, 1024, bus cycles to wait for ack/err before abort (range 2..65535).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1 / cmd_ready  output  1  command handshake.
REQ-007 cmd_adr  input  ADR_W / cmd_dat  input  DAT_W / cmd_sel  input  DAT_W/8 / cmd_we  input  1  command payload.
REQ-008 rsp_valid  output  1 / rsp_ready  input  1  response handshake.
REQ-009 rsp_dat  output  DAT_W / rsp_status  output  2  response payload (0 OK, 1 ERR, 2 TIMEOUT).
REQ-010 wishbone_adr  output  ADR_W / wishbone_dat_w  output  DAT_W / wishbone_sel  output  DAT_W/8 / wishbone_we  output  1.
REQ-011 wishbone_cyc, wishbone_stb  output  1 each; wishbone_cti  output  3; wishbone_bte  output  2.
REQ-012 wishbone_dat_r  input  DAT_W / wishbone_ack  input  1 / wishbone_err  input  1.
REQ-013 txn_count  output  16  completed-transaction counter.

Function
REQ-014 States IDLE, BUS, RESP; IDLE->BUS on cmd_valid&&cmd_ready; BUS->RESP on ack, err or timeout; RESP->IDLE on rsp_valid&&rsp_ready.
REQ-015 cmd_ready SHALL be 1 only in IDLE (not reset); payload captured into wishbone_adr/dat_w/sel/we on acceptance.
REQ-016 wishbone_cyc and wishbone_stb SHALL assert together the cycle after acceptance and stay high, payload stable, until termination.
REQ-017 Termination: the cycle ack, err or timeout is sampled high, cyc/stb SHALL deassert on the next edge (registered, one-cycle latency).
REQ-018 wishbone_cti SHALL be constant 3'b000, wishbone_bte constant 2'b00 (classic single cycles only).
REQ-019 On ack: rsp_dat = wishbone_dat_r sampled that cycle (write: value sampled, unused), rsp_status = 0.
REQ-020 On err: rsp_dat = 0, rsp_status = 1; ack and err simultaneously SHALL yield status 1.
REQ-021 Timeout counter SHALL clear on entering BUS, increment each BUS cycle; on reaching TIMEOUT-1 without ack/err, status 2, rsp_dat 0.
REQ-022 ack/err in the same cycle as timeout expiry SHALL win over timeout.
REQ-023 Minimum latency: cmd accepted cycle N, cyc high N+1, ack at N+1 -> rsp_valid at N+2.
REQ-024 rsp_valid SHALL hold with stable payload until rsp_ready; rsp_ready while rsp_valid low is ignored.
REQ-025 ack/err outside BUS SHALL be ignored.
REQ-026 txn_count SHALL increment by 1 on each RESP->IDLE transition, wrapping 0xFFFF->0x0000.

Reset
REQ-027 reset in any state SHALL return to IDLE next edge, abandoning any bus cycle and pending response.
REQ-028 Reset values: cyc, stb, we, rsp_valid, cmd_ready = 0; adr, dat_w, sel, rsp_dat, rsp_status, txn_count, timeout counter = 0.
REQ-029 cmd_ready SHALL rise the first cycle after reset deasserts.

Structure
REQ-030 Package wb_txn_pkg SHALL hold the state enum, status encodings (OK/ERR/TIMEOUT) and default width constants.
REQ-031 Timeout counter SHALL be sub-module wb_timeout_ctr (inputs clear, enable; output expired), parameterised by TIMEOUT.

Verification
REQ-032 Read adr 0x10, slave acks 1 cycle after stb with 0xDEADBEEF -> rsp_dat 0xDEADBEEF, status 0, cyc high exactly 2 cycles.
REQ-033 Write adr 0x04, dat 0x12345678, sel 0xF, ack after 3 wait states -> dat_w/sel/we stable throughout, status 0, txn_count +1.
REQ-034 TIMEOUT=8, slave never responds -> cyc drops after 8 BUS cycles, status 2, rsp_dat 0.
REQ-035 ack and err together on first stb cycle -> status 1; separately ack exactly at timeout expiry -> status 0.
REQ-036 rsp_ready held low 5 cycles -> rsp_valid/payload stable, cmd_ready 0; new cmd accepted the cycle after rsp_ready handshake.
REQ-037 reset asserted mid-BUS with cyc high -> next edge cyc/stb 0, rsp_valid 0, txn_count 0; cmd_ready 1 after release.
